// File: rtl/btn_reg_pkg.sv
// btn_reg_pkg: shared types and helpers for the button-driven shift register.
//   op_t     - action selected in a cycle
//   OPCNT_W  - width of the executed-action counter
//   prio_op  - fixed-priority encoder from the four button pulses to an op
package btn_reg_pkg;

    localparam int unsigned OPCNT_W = 8;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLR,
        OP_SET,
        OP_LOAD,
        OP_SHIFT
    } op_t;

    // p[0] = clear, p[1] = set, p[2] = load, p[3] = shift; lowest index wins.
    function automatic op_t prio_op(input logic [3:0] p);
        if (p[0])      return OP_CLR;
        else if (p[1]) return OP_SET;
        else if (p[2]) return OP_LOAD;
        else if (p[3]) return OP_SHIFT;
        else           return OP_NONE;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: synchronises one asynchronous button level and emits a
// single-cycle PULSE on each press (rising edge).
//   CLK   - system clock
//   RST   - asynchronous active-high reset
//   BTN   - raw button level from the board
//   PULSE - one-cycle pulse per press
// Optional debouncer enabled with macro BTN_DEBOUNCE_EN (window DB_CYCLES).
module btn_sync_edge #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic PULSE
);

    logic s1, s2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= BTN;
            s2 <= s1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          db, db_prev;
    logic [CW-1:0] cnt;

    // db follows s2 once s2 has disagreed with it for DB_CYCLES consecutive
    // cycles; the update lands on the DB_CYCLES-th disagreeing edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db      <= 1'b0;
            db_prev <= 1'b0;
            cnt     <= '0;
        end else begin
            db_prev <= db;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign PULSE = db & ~db_prev;
`else
    logic s3;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) s3 <= 1'b0;
        else     s3 <= s2;
    end

    assign PULSE = s2 & ~s3;
`endif

endmodule

// File: rtl/btn_shift_reg.sv
// btn_shift_reg: WIDTH-bit register controlled by four push buttons.
//   CLK, RST        - clock, asynchronous active-high reset
//   BTN0..BTN3      - clear / set-all / parallel load / shift requests
//   D               - parallel load data
//   DIR             - shift direction (0 = toward MSB, 1 = toward LSB)
//   ROT             - 1 = rotate, 0 = shift in SI
//   SI              - serial input
//   Q               - register contents
//   SO              - last bit shifted/rotated out
//   OPCNT           - executed-action count (wraps)
// Define BTN_DEBOUNCE_EN to debounce each button over DB_CYCLES cycles.
module btn_shift_reg
    import btn_reg_pkg::*;
#(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    parameter int unsigned           DB_CYCLES = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               BTN0,
    input  logic               BTN1,
    input  logic               BTN2,
    input  logic               BTN3,
    input  logic [WIDTH-1:0]   D,
    input  logic               DIR,
    input  logic               ROT,
    input  logic               SI,
    output logic [WIDTH-1:0]   Q,
    output logic               SO,
    output logic [OPCNT_W-1:0] OPCNT
);

    logic [3:0]       pulse;
    op_t              op;
    logic [WIDTH-1:0] q_shift;
    logic             so_next;

    btn_sync_edge #(.DB_CYCLES(DB_CYCLES)) u_btn0 (.CLK(CLK), .RST(RST), .BTN(BTN0), .PULSE(pulse[0]));
    btn_sync_edge #(.DB_CYCLES(DB_CYCLES)) u_btn1 (.CLK(CLK), .RST(RST), .BTN(BTN1), .PULSE(pulse[1]));
    btn_sync_edge #(.DB_CYCLES(DB_CYCLES)) u_btn2 (.CLK(CLK), .RST(RST), .BTN(BTN2), .PULSE(pulse[2]));
    btn_sync_edge #(.DB_CYCLES(DB_CYCLES)) u_btn3 (.CLK(CLK), .RST(RST), .BTN(BTN3), .PULSE(pulse[3]));

    always_comb op = prio_op(pulse);

    always_comb so_next = DIR ? Q[0] : Q[WIDTH-1];

    // A 1-bit register has no slice to keep, so it is handled separately.
    if (WIDTH == 1) begin : g_w1
        always_comb q_shift = ROT ? Q : SI;
    end else begin : g_wn
        logic fill;
        always_comb begin
            fill    = ROT ? so_next : SI;
            q_shift = DIR ? {fill, Q[WIDTH-1:1]} : {Q[WIDTH-2:0], fill};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Q     <= RESET_VAL;
            SO    <= 1'b0;
            OPCNT <= '0;
        end else begin
            case (op)
                OP_CLR:   Q <= '0;
                OP_SET:   Q <= '1;
                OP_LOAD:  Q <= D;
                OP_SHIFT: begin
                    Q  <= q_shift;
                    SO <= so_next;
                end
                default:  ;
            endcase
            if (op != OP_NONE) OPCNT <= OPCNT + OPCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_btn_shift_reg.sv
module tb_btn_shift_reg;

    localparam int unsigned DBC = 4;
`ifdef BTN_DEBOUNCE_EN
    localparam int unsigned EXTRA = DBC;
`else
    localparam int unsigned EXTRA = 0;
`endif
    localparam int unsigned HOLD   = 3 + EXTRA;
    localparam int unsigned SETTLE = 4 + EXTRA;

    logic       CLK = 1'b0;
    logic       RST;
    logic       BTN0, BTN1, BTN2, BTN3;
    logic [7:0] D;
    logic       DIR, ROT, SI;
    logic [7:0] Q;
    logic       SO;
    logic [7:0] OPCNT;

    int ntests = 0;
    int nfail  = 0;

    btn_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .DB_CYCLES(DBC)) dut (
        .CLK(CLK), .RST(RST),
        .BTN0(BTN0), .BTN1(BTN1), .BTN2(BTN2), .BTN3(BTN3),
        .D(D), .DIR(DIR), .ROT(ROT), .SI(SI),
        .Q(Q), .SO(SO), .OPCNT(OPCNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [3:0] m);
        {BTN3, BTN2, BTN1, BTN0} = m;
    endtask

    task automatic press(input logic [3:0] m);
        @(posedge CLK); #1; set_btn(m);
        repeat (HOLD) @(posedge CLK);
        #1; set_btn(4'b0000);
        repeat (SETTLE) @(posedge CLK);
        #1;
    endtask

    // Caller raised a button just after an edge; the next edge is k.
    task automatic lat_check(input string tag, input logic [7:0] oldq,
                             input logic [7:0] newq, input logic [7:0] newcnt);
        @(posedge CLK); #1;
        repeat (1 + EXTRA) begin @(posedge CLK); #1; end
        chk({tag, "_early"}, Q, oldq);
        @(posedge CLK); #1;
        chk({tag, "_q"}, Q, newq);
        chk({tag, "_cnt"}, OPCNT, newcnt);
    endtask

    initial begin
        RST = 1'b1; set_btn(4'b0000);
        D = 8'h00; DIR = 1'b0; ROT = 1'b0; SI = 1'b0;
        #2;
        chk("rst_q", Q, 8'hA5);
        chk("rst_so", SO, 1'b0);
        chk("rst_cnt", OPCNT, 8'd0);
        repeat (3) @(posedge CLK);
        #1; RST = 1'b0;
        repeat (2) @(posedge CLK);

        // Load with latency check, then held: still exactly one action.
        #1; D = 8'h3C; BTN2 = 1'b1;
        lat_check("load", 8'hA5, 8'h3C, 8'd1);
        repeat (7) @(posedge CLK);
        #1;
        chk("hold_cnt", OPCNT, 8'd1);
        chk("hold_so", SO, 1'b0);
        BTN2 = 1'b0;
        repeat (SETTLE) @(posedge CLK);

        // Shift left, SI in
        D = 8'h81; press(4'b0100);
        DIR = 1'b0; ROT = 1'b0; SI = 1'b1; press(4'b1000);
        chk("shl_q", Q, 8'h03);
        chk("shl_so", SO, 1'b1);
        chk("shl_cnt", OPCNT, 8'd3);

        // Rotate left
        press(4'b0100);
        ROT = 1'b1; SI = 1'b0; press(4'b1000);
        chk("rol_q", Q, 8'h03);
        chk("rol_so", SO, 1'b1);
        D = 8'h40; press(4'b0100);
        SI = 1'b1; press(4'b1000);
        chk("rol2_q", Q, 8'h80);
        chk("rol2_so", SO, 1'b0);
        ROT = 1'b0; SI = 1'b0; press(4'b1000);
        chk("shl0_q", Q, 8'h00);
        chk("shl0_so", SO, 1'b1);
        chk("shl0_cnt", OPCNT, 8'd8);

        // Shift / rotate right
        D = 8'h01; press(4'b0100);
        DIR = 1'b1; ROT = 1'b0; SI = 1'b0; press(4'b1000);
        chk("shr_q", Q, 8'h00);
        chk("shr_so", SO, 1'b1);
        D = 8'h02; press(4'b0100);
        ROT = 1'b1; press(4'b1000);
        chk("ror_q", Q, 8'h01);
        chk("ror_so", SO, 1'b0);
        press(4'b1000);
        chk("ror2_q", Q, 8'h80);
        chk("ror2_so", SO, 1'b1);
        ROT = 1'b0; SI = 1'b1; press(4'b1000);
        chk("shr1_q", Q, 8'hC0);
        chk("shr1_so", SO, 1'b0);
        chk("shr_cnt", OPCNT, 8'd14);

        // Set and clear leave SO alone
        press(4'b0010);
        chk("set_q", Q, 8'hFF);
        chk("set_so", SO, 1'b0);
        DIR = 1'b0; SI = 1'b0; press(4'b1000);
        chk("shl_fe_q", Q, 8'hFE);
        chk("shl_fe_so", SO, 1'b1);
        press(4'b0010);
        chk("set2_q", Q, 8'hFF);
        chk("set2_so", SO, 1'b1);

        // Simultaneous presses: highest priority only, one count
        press(4'b0011);
        chk("clrset_q", Q, 8'h00);
        chk("clrset_cnt", OPCNT, 8'd18);
        chk("clrset_so", SO, 1'b1);
        D = 8'h5A; press(4'b1100);
        chk("ldsh_q", Q, 8'h5A);
        chk("ldsh_so", SO, 1'b1);
        press(4'b0110);
        chk("setld_q", Q, 8'hFF);
        chk("setld_cnt", OPCNT, 8'd20);

        // Async reset mid-cycle while a button is held
        @(posedge CLK); #1; D = 8'h77; BTN2 = 1'b1;
        @(posedge CLK); #3; RST = 1'b1;
        #1;
        chk("arst_q", Q, 8'hA5);
        chk("arst_so", SO, 1'b0);
        chk("arst_cnt", OPCNT, 8'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk("arst_hold_q", Q, 8'hA5);
        RST = 1'b0;
        lat_check("postrst", 8'hA5, 8'h77, 8'd1);
        BTN2 = 1'b0;
        repeat (SETTLE) @(posedge CLK);

        // Counter wrap
        for (int i = 1; i <= 254; i++) begin
            D = 8'(i); press(4'b0100);
        end
        chk("cnt_255", OPCNT, 8'd255);
        chk("cnt_255_q", Q, 8'd254);
        D = 8'hC3; press(4'b0100);
        chk("cnt_wrap", OPCNT, 8'd0);
        chk("cnt_wrap_q", Q, 8'hC3);

`ifdef BTN_DEBOUNCE_EN
        // Three-sample glitch is filtered
        @(posedge CLK); #1; D = 8'hE7; BTN2 = 1'b1;
        repeat (3) @(posedge CLK);
        #1; BTN2 = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        chk("glitch_q", Q, 8'hC3);
        chk("glitch_cnt", OPCNT, 8'd0);
        BTN2 = 1'b1;
        lat_check("db", 8'hC3, 8'hE7, 8'd1);
        BTN2 = 1'b0;
        repeat (SETTLE) @(posedge CLK);
        #1;
        chk("db_once", OPCNT, 8'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
